// File: rtl/pll_seq_pkg.sv
// Shared state encoding and elaboration-time helpers for the PLL lock sequencer.
// Pure declarations: no latency, no flow control.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILTER = 2'd1,
    HOLD   = 2'd2,
    RUN    = 2'd3
  } seq_state_t;

  function automatic bit params_ok(input int sync_stages, input int lock_filter,
                                   input int reset_hold, input int loss_cnt_w);
    return (sync_stages >= 2) && (lock_filter >= 1) && (reset_hold >= 1) && (loss_cnt_w >= 1);
  endfunction

  // One shared counter serves both the filter and the hold window.
  function automatic int cnt_width(input int lock_filter, input int reset_hold);
    int m;
    m = (lock_filter > reset_hold) ? lock_filter : reset_hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_bits.sv
// N-flop synchroniser with synchronous active-low clear; latency N edges.
// No flow control: samples every edge.
module sync_bits #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] stage;

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[N-2:0], d};
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Turns the PLL lock flag into a filtered, held, synchronous core reset; release after
// SYNC_STAGES+LOCK_FILTER+RESET_HOLD-1 edges, loss seen after SYNC_STAGES edges; no backpressure.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 1024,
  parameter int RESET_HOLD  = 16,
  parameter int LOSS_CNT_W  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  output logic                  core_reset_n,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int CNT_W = cnt_width(LOCK_FILTER, RESET_HOLD);
  // The IDLE->FILTER edge is already the first stable sample, so the filter
  // is satisfied once LOCK_FILTER-1 further samples have been counted.
  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD);

  if (!params_ok(SYNC_STAGES, LOCK_FILTER, RESET_HOLD, LOSS_CNT_W)) begin : g_param_check
    $error("pll_lock_sequencer: illegal parameter set");
  end

  logic             locked_s;
  seq_state_t       state;
  logic [CNT_W-1:0] cnt;

  sync_bits #(
    .N (SYNC_STAGES),
    .W (1)
  ) u_lock_sync (
    .clock   (clock),
    .clear_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      loss_count   <= '0;
    end else begin
      lock_lost    <= 1'b0;
      core_reset_n <= 1'b0;
      ready        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (locked_s) begin
            state <= FILTER;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        FILTER: begin
          if (!locked_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= FILTER_LAST) begin
            state <= HOLD;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state        <= RUN;
            cnt          <= '0;
            core_reset_n <= 1'b1;
            ready        <= 1'b1;
          end else begin
            cnt   <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            // Only a loss while running is an event worth counting.
            state     <= IDLE;
            cnt       <= '0;
            lock_lost <= 1'b1;
            if (loss_count != '1) begin
              loss_count <= loss_count + LOSS_CNT_W'(1);
            end
          end else begin
            core_reset_n <= 1'b1;
            ready        <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with SYNC_STAGES=2, LOCK_FILTER=4, RESET_HOLD=3, LOSS_CNT_W=2.
// Expected release is 8 edges after the first high sample; loss shows 2 edges after the first low sample.
module tb_pll_lock_sequencer;

  logic       clock;
  logic       reset_n;
  logic       pll_locked;
  logic       core_reset_n;
  logic       ready;
  logic       lock_lost;
  logic [1:0] loss_count;

  int checks;
  int fails;

  pll_lock_sequencer #(
    .SYNC_STAGES (2),
    .LOCK_FILTER (4),
    .RESET_HOLD  (3),
    .LOSS_CNT_W  (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .core_reset_n (core_reset_n),
    .ready        (ready),
    .lock_lost    (lock_lost),
    .loss_count   (loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one active edge and park on the following falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    tick();
    tick();
    checks++; if (core_reset_n !== 1'b0) begin fails++; $display("FAIL reset_core_reset_n: got %b expected 0", core_reset_n); end
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); end
    checks++; if (loss_count !== 2'd0) begin fails++; $display("FAIL reset_loss_count: got %0d expected 0", loss_count); end
  endtask

  // pll_locked already high; first edge with reset_n high is edge 0.
  task automatic test_release();
    logic exp;
    reset_n = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      exp = (e >= 8);
      checks++; if (core_reset_n !== exp) begin fails++; $display("FAIL release_core_reset_n edge %0d: got %b expected %b", e, core_reset_n, exp); end
      checks++; if (ready !== exp) begin fails++; $display("FAIL release_ready edge %0d: got %b expected %b", e, ready, exp); end
      checks++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL release_lock_lost edge %0d: got %b expected 0", e, lock_lost); end
    end
  endtask

  task automatic test_glitch();
    logic exp;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    for (int e = 0; e <= 14; e++) begin
      pll_locked = (e == 4) ? 1'b0 : 1'b1;
      tick();
      exp = (e >= 13);
      checks++; if (core_reset_n !== exp) begin fails++; $display("FAIL glitch_core_reset_n edge %0d: got %b expected %b", e, core_reset_n, exp); end
      checks++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL glitch_lock_lost edge %0d: got %b expected 0", e, lock_lost); end
    end
    checks++; if (loss_count !== 2'd0) begin fails++; $display("FAIL glitch_loss_count: got %0d expected 0", loss_count); end
  endtask

  // From IDLE with locked_s low: raise the lock and expect release after the 9th edge.
  task automatic test_acquire(input string tag);
    pll_locked = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++; if (core_reset_n !== 1'b0) begin fails++; $display("FAIL %s_early_release edge %0d: got %b expected 0", tag, e, core_reset_n); end
    end
    tick();
    checks++; if (core_reset_n !== 1'b1) begin fails++; $display("FAIL %s_core_reset_n: got %b expected 1", tag, core_reset_n); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL %s_ready: got %b expected 1", tag, ready); end
  endtask

  // From RUN: drop the lock at edge k; the loss becomes visible after edge k+2.
  task automatic test_drop(input int exp_count, input string tag);
    pll_locked = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      checks++; if (core_reset_n !== 1'b1) begin fails++; $display("FAIL %s_early_drop edge k+%0d: got %b expected 1", tag, e, core_reset_n); end
      checks++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL %s_early_pulse edge k+%0d: got %b expected 0", tag, e, lock_lost); end
    end
    tick();
    checks++; if (core_reset_n !== 1'b0) begin fails++; $display("FAIL %s_core_reset_n: got %b expected 0", tag, core_reset_n); end
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL %s_ready: got %b expected 0", tag, ready); end
    checks++; if (lock_lost !== 1'b1) begin fails++; $display("FAIL %s_lock_lost: got %b expected 1", tag, lock_lost); end
    checks++; if (loss_count !== exp_count[1:0]) begin fails++; $display("FAIL %s_loss_count: got %0d expected %0d", tag, loss_count, exp_count); end
    tick();
    checks++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL %s_pulse_width: got %b expected 0", tag, lock_lost); end
    checks++; if (loss_count !== exp_count[1:0]) begin fails++; $display("FAIL %s_loss_count_hold: got %0d expected %0d", tag, loss_count, exp_count); end
  endtask

  task automatic test_loss();
    test_drop(1, "loss");
  endtask

  task automatic test_saturation();
    int exp_cnt [3] = '{2, 3, 3};
    for (int i = 0; i < 3; i++) begin
      test_acquire($sformatf("sat_acquire%0d", i));
      test_drop(exp_cnt[i], $sformatf("sat_drop%0d", i));
    end
  endtask

  task automatic test_reset_in_run();
    test_acquire("rr_acquire");
    reset_n = 1'b0;
    tick();
    checks++; if (core_reset_n !== 1'b0) begin fails++; $display("FAIL rr_core_reset_n: got %b expected 0", core_reset_n); end
    checks++; if (ready !== 1'b0) begin fails++; $display("FAIL rr_ready: got %b expected 0", ready); end
    checks++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL rr_lock_lost: got %b expected 0", lock_lost); end
    checks++; if (loss_count !== 2'd0) begin fails++; $display("FAIL rr_loss_count: got %0d expected 0", loss_count); end
    reset_n = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++; if (core_reset_n !== 1'b0) begin fails++; $display("FAIL rr_early_release edge %0d: got %b expected 0", e, core_reset_n); end
      checks++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL rr_spurious_pulse edge %0d: got %b expected 0", e, lock_lost); end
    end
    tick();
    checks++; if (core_reset_n !== 1'b1) begin fails++; $display("FAIL rr_release: got %b expected 1", core_reset_n); end
    checks++; if (ready !== 1'b1) begin fails++; $display("FAIL rr_ready_release: got %b expected 1", ready); end
    checks++; if (loss_count !== 2'd0) begin fails++; $display("FAIL rr_loss_count_after: got %0d expected 0", loss_count); end
  endtask

  initial begin
    checks     = 0;
    fails      = 0;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    @(negedge clock);
    test_reset();
    test_release();
    test_glitch();
    test_loss();
    test_saturation();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
